// File: rtl/pdl_burst_sched.sv
// pdl_burst_sched: burst scheduler and shadow/active config controller for OUT_NUM pdl channels
// Ports: clk, reset (async, active-high); trigger (async external);
//        cfg_we/cfg_field/cfg_addr/cfg_data shadow writes; burst_num/burst_period sampled in LOAD;
//        ch_trig per-channel pulses; ch_dl/ch_wb active settings packed [N*i +: N];
//        busy, done, burst_idx, overrun status.
module pdl_burst_sched #(
    parameter int N       = 32,
    parameter int OUT_NUM = 8,
    parameter int AW      = 3,
    parameter int TRIG_HI = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_field,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [N-1:0]           cfg_data,
    input  logic [15:0]            burst_num,
    input  logic [N-1:0]           burst_period,
    output logic [OUT_NUM-1:0]     ch_trig,
    output logic [N*OUT_NUM-1:0]   ch_dl,
    output logic [N*OUT_NUM-1:0]   ch_wb,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            burst_idx,
    output logic                   overrun
);
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, GAP, DONE} state_t;
    localparam logic [N-1:0] MIN_P   = N'(2 * TRIG_HI);
    localparam logic [N-1:0] HI_LAST = N'(TRIG_HI - 1);
    state_t state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [OUT_NUM-1:0][N-1:0] sh_dl_q, sh_dl_d, sh_wb_q, sh_wb_d, act_dl_q, act_dl_d, act_wb_q, act_wb_d;
    logic [OUT_NUM-1:0] sh_mask_q, sh_mask_d, act_mask_q, act_mask_d, trig_q, trig_d;
    logic [15:0] bn_q, bn_d, idx_q, idx_d;
    logic [N-1:0] per_q, per_d, cnt_q, cnt_d;
    logic rise;
    assign rise      = sync_q[1] & ~sync_q[2];
    assign ch_trig   = trig_q;
    assign ch_dl     = act_dl_q;
    assign ch_wb     = act_wb_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign burst_idx = idx_q;
    assign overrun   = rise & (state_q != IDLE);
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[1:0], trigger};
        sh_dl_d    = sh_dl_q;
        sh_wb_d    = sh_wb_q;
        sh_mask_d  = sh_mask_q;
        act_dl_d   = act_dl_q;
        act_wb_d   = act_wb_q;
        act_mask_d = act_mask_q;
        bn_d       = bn_q;
        per_d      = per_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        if (cfg_we && int'(cfg_addr) < OUT_NUM) begin
            case (cfg_field)
                2'b00:   sh_dl_d[cfg_addr] = cfg_data;
                2'b01:   sh_wb_d[cfg_addr] = cfg_data;
                2'b10:   sh_mask_d = cfg_data[OUT_NUM-1:0];
                default: ;
            endcase
        end
        case (state_q)
            IDLE: state_d = rise ? LOAD : IDLE;
            LOAD: begin
                // commit uses the pre-edge shadow, so a write in this cycle waits for the next burst
                act_dl_d   = sh_dl_q;
                act_wb_d   = sh_wb_q;
                act_mask_d = sh_mask_q;
                bn_d       = burst_num;
                per_d      = (burst_period >= MIN_P) ? burst_period : MIN_P;
                cnt_d      = '0;
                idx_d      = '0;
                state_d    = (burst_num == 16'd0) ? DONE : FIRE;
            end
            FIRE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == HI_LAST) ? GAP : FIRE;
            end
            GAP: begin
                if (cnt_q == per_q - 1'b1) begin
                    if (idx_q == bn_q - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        cnt_d   = '0;
                        state_d = FIRE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // registered from next state so pulses start on the LOAD->FIRE edge with no glitches
        trig_d = (state_d == FIRE) ? act_mask_d : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            sh_dl_q    <= '0;
            sh_wb_q    <= '0;
            sh_mask_q  <= '0;
            act_dl_q   <= '0;
            act_wb_q   <= '0;
            act_mask_q <= '0;
            trig_q     <= '0;
            bn_q       <= '0;
            per_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            sh_dl_q    <= sh_dl_d;
            sh_wb_q    <= sh_wb_d;
            sh_mask_q  <= sh_mask_d;
            act_dl_q   <= act_dl_d;
            act_wb_q   <= act_wb_d;
            act_mask_q <= act_mask_d;
            trig_q     <= trig_d;
            bn_q       <= bn_d;
            per_q      <= per_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
        end
    end
endmodule

// File: tb/tb_pdl_burst_sched.sv
// tb_pdl_burst_sched: directed table-driven bench for pdl_burst_sched
module tb_pdl_burst_sched;
    logic clk = 0, reset = 1, trigger = 0, cfg_we = 0;
    logic [1:0] cfg_field = 0;
    logic [2:0] cfg_addr = 0;
    logic [31:0] cfg_data = 0, burst_period = 0;
    logic [15:0] burst_num = 0, burst_idx;
    logic [7:0] ch_trig;
    logic [255:0] ch_dl, ch_wb;
    logic busy, done, overrun;
    int checks = 0, errors = 0;

    pdl_burst_sched dut (
        .clk(clk), .reset(reset), .trigger(trigger), .cfg_we(cfg_we), .cfg_field(cfg_field),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .burst_num(burst_num), .burst_period(burst_period),
        .ch_trig(ch_trig), .ch_dl(ch_dl), .ch_wb(ch_wb), .busy(busy), .done(done),
        .burst_idx(burst_idx), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bn, per, p, done_e, ch;
        logic [7:0] mask;
        logic [31:0] dl, wb;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] f, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1; cfg_field = f; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic run_burst(input int bn, input int per, input logic [7:0] mask, input int p,
                             input int done_e, input int ch, input logic [31:0] dl, input logic [31:0] wb,
                             input int wr_at, input logic [31:0] wr_val, input int ovr_at);
        logic [7:0] t_exp;
        burst_num = 16'(bn);
        burst_period = 32'(per);
        @(negedge clk);
        trigger = 1;
        for (int e = 1; e <= done_e + 1; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) trigger = 0;
            t_exp = (e >= 4 && e < done_e && ((e - 4) % p) < 4) ? mask : 8'h00;
            chk($sformatf("ch_trig e%0d", e), 64'(ch_trig), 64'(t_exp));
            chk($sformatf("busy e%0d", e), 64'(busy), 64'(e >= 3 && e <= done_e));
            chk($sformatf("done e%0d", e), 64'(done), 64'(e == done_e));
            chk($sformatf("overrun e%0d", e), 64'(overrun), 64'(ovr_at > 0 && e == ovr_at + 2));
            if (e >= 4 && e < done_e) chk($sformatf("burst_idx e%0d", e), 64'(burst_idx), 64'((e - 4) / p));
            if (e == done_e) chk("burst_idx at done", 64'(burst_idx), 64'(bn == 0 ? 0 : bn - 1));
            if (e >= 4) begin
                chk($sformatf("ch_dl e%0d", e), 64'(ch_dl[ch*32 +: 32]), 64'(dl));
                chk($sformatf("ch_wb e%0d", e), 64'(ch_wb[ch*32 +: 32]), 64'(wb));
            end
            if (wr_at > 0 && e == wr_at) begin
                cfg_we = 1; cfg_field = 2'b00; cfg_addr = 3'(ch); cfg_data = wr_val;
            end
            if (wr_at > 0 && e == wr_at + 1) cfg_we = 0;
            if (ovr_at > 0 && e == ovr_at) trigger = 1;
            if (ovr_at > 0 && e == ovr_at + 1) trigger = 0;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{bn: 1, per: 20, p: 20, done_e: 24, ch: 0, mask: 8'h01, dl: 10,  wb: 5};
        tbl[1] = '{bn: 3, per: 3,  p: 8,  done_e: 28, ch: 7, mask: 8'h81, dl: 33,  wb: 44};
        tbl[2] = '{bn: 0, per: 20, p: 20, done_e: 4,  ch: 0, mask: 8'h01, dl: 7,   wb: 8};
        tbl[3] = '{bn: 2, per: 8,  p: 8,  done_e: 20, ch: 2, mask: 8'hA5, dl: 100, wb: 200};
        tbl[4] = '{bn: 2, per: 9,  p: 9,  done_e: 22, ch: 5, mask: 8'h3C, dl: 1,   wb: 2};

        repeat (3) @(negedge clk);
        chk("reset ch_trig", 64'(ch_trig), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
        chk("reset ch_dl", 64'(ch_dl[63:0]), 0);
        reset = 0;
        @(negedge clk);
        chk("post-reset burst_idx", 64'(burst_idx), 0);
        chk("post-reset overrun", 64'(overrun), 0);

        for (int i = 0; i < 5; i++) begin
            cfg_write(2'b00, 3'(tbl[i].ch), tbl[i].dl);
            cfg_write(2'b01, 3'(tbl[i].ch), tbl[i].wb);
            cfg_write(2'b11, 3'(tbl[i].ch), 32'hDEAD);
            cfg_write(2'b10, 3'd0, 32'(tbl[i].mask));
            repeat (3) @(negedge clk);
            run_burst(tbl[i].bn, tbl[i].per, tbl[i].mask, tbl[i].p, tbl[i].done_e, tbl[i].ch,
                      tbl[i].dl, tbl[i].wb, 0, 0, 0);
        end

        // shadow isolation: mid-burst write shows up only at the next LOAD
        cfg_write(2'b00, 3'd0, 32'd10);
        cfg_write(2'b01, 3'd0, 32'd5);
        cfg_write(2'b10, 3'd0, 32'h01);
        run_burst(2, 20, 8'h01, 20, 44, 0, 10, 5, 10, 99, 0);
        run_burst(2, 20, 8'h01, 20, 44, 0, 99, 5, 0, 0, 0);

        // overrun mid-GAP, then a normal trigger
        cfg_write(2'b10, 3'd0, 32'h0F);
        run_burst(3, 10, 8'h0F, 10, 34, 0, 99, 5, 0, 0, 7);
        run_burst(3, 10, 8'h0F, 10, 34, 0, 99, 5, 0, 0, 0);

        // reset during the second FIRE cycle
        cfg_write(2'b10, 3'd0, 32'hFF);
        burst_num = 2;
        burst_period = 8;
        @(negedge clk);
        trigger = 1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) trigger = 0;
        end
        chk("pre-reset ch_trig", 64'(ch_trig), 64'hFF);
        reset = 1;
        #1;
        chk("mid reset ch_trig", 64'(ch_trig), 0);
        chk("mid reset busy", 64'(busy), 0);
        chk("mid reset ch_dl", 64'(ch_dl), 0);
        chk("mid reset ch_wb", 64'(ch_wb), 0);
        chk("mid reset done", 64'(done), 0);
        @(negedge clk);
        reset = 0;
        begin
            int seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) seen++;
            end
            chk("no done after reset", 64'(seen), 0);
        end
        run_burst(1, 8, 8'h00, 8, 12, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdl_burst_sched.md
Name: pdl_burst_sched

Overview:
Burst scheduler and configuration controller for a bank of OUT_NUM pdl pulse-delay channels. It holds per-channel delay/width settings and an enable mask in shadow registers, and commits them to stable active outputs at burst start. On a synchronized external trigger it fires a burst of trigger pulses to the enabled channels at a programmable period. It sits between the host config interface and the pdl channel instances.

Parameters:
N, 32, width of delay, width and period values (10 ns units)
OUT_NUM, 8, number of downstream pdl channels
AW, 3, config address width (log2 OUT_NUM)
TRIG_HI, 4, cycles each ch_trig pulse is held high

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-high reset
trigger  in  1  external trigger, asynchronous to clk
cfg_we  in  1  config write strobe, one write per cycle
cfg_field  in  2  00 = dl[addr], 01 = wb[addr], 10 = enable mask, 11 = reserved (write ignored)
cfg_addr  in  AW  channel index
cfg_data  in  N  write data
burst_num  in  16  pulses per burst, sampled in LOAD
burst_period  in  N  cycles between pulse starts, sampled in LOAD
ch_trig  out  OUT_NUM  per-channel trigger to the pdl trigger inputs
ch_dl  out  N*OUT_NUM  active delay; channel i occupies [N*i +: N]
ch_wb  out  N*OUT_NUM  active width; same packing as ch_dl
busy  out  1  high in LOAD, FIRE, GAP and DONE
done  out  1  one-cycle pulse when a burst ends
burst_idx  out  16  index of the current or last pulse in the burst
overrun  out  1  one-cycle pulse when a trigger is ignored

Behaviour:
- Reset is asynchronous. It clears all shadow and active registers, the enable mask, the counters and every output to 0, and puts the FSM in IDLE. ch_trig drops immediately on reset. Reset mid-burst produces no done pulse.
- Trigger path: 3-FF synchronizer, sync1 -> sync2 -> sync3; rise = sync2 & ~sync3.
- Config: writes go to the shadow registers only and may occur in any state.
  - Writes with cfg_addr >= OUT_NUM are ignored.
  - Enable mask write: mask = cfg_data[OUT_NUM-1:0].
  - A write in the LOAD cycle lands in shadow but is not committed until the next burst.
- Effective period: P = burst_period if burst_period >= 2*TRIG_HI, otherwise P = 2*TRIG_HI.
- FSM:
  - IDLE: on rise, go to LOAD.
  - LOAD (1 cycle): copy shadow dl/wb/mask to active; latch burst_num and P; clear the period counter and burst_idx. If burst_num == 0, go to DONE; otherwise go to FIRE.
  - FIRE (TRIG_HI cycles): ch_trig = active mask; the period counter runs from 0. Then go to GAP.
  - GAP: ch_trig = 0. When the period counter reaches P-1:
    - if burst_idx == burst_num-1, go to DONE;
    - otherwise increment burst_idx, clear the counter and go to FIRE.
  - DONE (1 cycle): done = 1, then go to IDLE.
- Latency: counting the edge where sync1 first captures 1 as edge 1, LOAD is entered at edge 3. ch_trig rises at edge 4. Pulse k rises at edge 4 + k*P. done is high at edge 4 + burst_num*P.
- Timing of outputs:
  - ch_trig is registered, glitch-free, and held exactly TRIG_HI cycles per pulse.
  - Channels with mask bit 0 stay at 0.
  - ch_dl and ch_wb change only at LOAD and are stable for the whole burst.
- Overrun: a rise seen in any state other than IDLE (including DONE) is ignored and overrun pulses for 1 cycle. The running burst is unaffected.
- Counter widths: the period counter is N bits and burst_idx is 16 bits; neither wraps within a legal burst.

Test Plan:
- Reset; write dl[0]=10, wb[0]=5, mask=0x01; burst_num=1, period=20; trigger -> ch_trig[0] high edges 4-7, ch_trig[7:1]=0, ch_dl[31:0]=10, ch_wb[31:0]=5, done at edge 24, busy high edges 3-24.
- burst_num=3, period=3, mask=0x81 -> P=8; ch_trig[0] and ch_trig[7] rise at edges 4, 12, 20, each 4 cycles wide; burst_idx 0, 1, 2; done at edge 28.
- Shadow isolation: during a burst write dl[0]=99 -> ch_dl[31:0] keeps its old value to burst end; the next trigger's LOAD shows 99.
- Second trigger mid-GAP -> overrun 1-cycle pulse; pulse count and done timing unchanged. Trigger after IDLE is accepted normally.
- Assert reset in the 2nd FIRE cycle -> ch_trig=0 immediately; busy=0; ch_dl/ch_wb=0; no done; the next trigger with mask=0 fires nothing.
- burst_num=0 -> no ch_trig activity; done at edge 4; busy edges 3-4.
